// File: rtl/display_scan_controller.sv
// display_scan_controller
//   Time-multiplexed scan controller for a 4-digit seven-segment display.
//   Walks the external digit parser through ones/tens/hundreds/thousands,
//   registers the decoded segment pattern, and drives active-low anodes.
//   Each digit slot is BLANK_CYCLES of all-anodes-off, followed by
//   DWELL_CYCLES of the digit lit. New values are committed only at frame
//   boundaries.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   value_in     value requested for display (0-255)
//   value_valid  single-cycle load strobe for value_in
//   shown_value  committed value, feeds the digit parser
//   digit_select parser select: 0 ones, 1 tens, 3 hundreds, 4 thousands
//   digit_in     BCD digit returned by the parser
//   anode        active-low digit enables, [0] ones .. [3] thousands
//   segments     active-low {g,f,e,d,c,b,a}
//   frame_tick   one-cycle pulse at the start of each frame
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, leading-zero digits are blanked
//                          (the ones digit is always shown).

module display_scan_controller #(
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value_in,
  input  logic       value_valid,
  output logic [7:0] shown_value,
  output logic [2:0] digit_select,
  input  logic [3:0] digit_in,
  output logic [3:0] anode,
  output logic [6:0] segments,
  output logic       frame_tick
);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic {
    BLANK,
    ON
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [7:0]       pending;
  logic             pending_valid;
  logic [6:0]       seg_next;
  logic             commit;

  // Slot index to parser select code (code 2 is unused by the parser).
  function automatic logic [2:0] sel_of(input logic [1:0] i);
    case (i)
      2'd0:    sel_of = 3'd0;
      2'd1:    sel_of = 3'd1;
      2'd2:    sel_of = 3'd3;
      default: sel_of = 3'd4;
    endcase
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    seg_next = decode(digit_in);
`ifdef LEADING_ZERO_BLANK_EN
    // digit_select and shown_value are the same registers the parser sees,
    // so the blanking decision lines up with digit_in in the same cycle.
    if ((digit_select == 3'd4) ||
        (digit_select == 3'd3 && shown_value < 8'd100) ||
        (digit_select == 3'd1 && shown_value < 8'd10))
      seg_next = '1;
`endif
  end

  // Last ON cycle of the thousands slot: the edge that starts a new frame.
  assign commit = (state == ON) && (cnt == DWELL_LAST) && (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= BLANK;
      cnt           <= '0;
      idx           <= '0;
      anode         <= '1;
      segments      <= '1;
      digit_select  <= 3'd0;
      shown_value   <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      frame_tick    <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      segments   <= seg_next;

      // A strobe on the commit edge bypasses pending and is shown directly.
      if (commit) begin
        if (value_valid)
          shown_value <= value_in;
        else if (pending_valid)
          shown_value <= pending;
        pending_valid <= 1'b0;
      end else if (value_valid) begin
        pending       <= value_in;
        pending_valid <= 1'b1;
      end

      case (state)
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state <= ON;
            cnt   <= '0;
            anode <= ~(4'b0001 << idx);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ON: begin
          if (cnt == DWELL_LAST) begin
            state        <= BLANK;
            cnt          <= '0;
            idx          <= idx + 2'd1;
            digit_select <= sel_of(idx + 2'd1);
            anode        <= '1;
            frame_tick   <= (idx == 2'd3);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= BLANK;
          cnt   <= '0;
          anode <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
module tb_display_scan_controller;

  localparam int unsigned DW    = 4;
  localparam int unsigned BL    = 2;
  localparam int unsigned SLOT  = DW + BL;
  localparam int unsigned FRAME = 4 * SLOT;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] value_in;
  logic       value_valid;
  logic [7:0] shown_value;
  logic [2:0] digit_select;
  logic [3:0] digit_in;
  logic [3:0] anode;
  logic [6:0] segments;
  logic       frame_tick;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int unsigned t;
  logic [7:0]  shown_m;
  logic [7:0]  pend_m;
  logic        pv_m;
  logic [6:0]  seg_exp;

  logic [2:0] selmap [4] = '{3'd0, 3'd1, 3'd3, 3'd4};
  logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000};

  display_scan_controller #(
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .value_in(value_in),
    .value_valid(value_valid),
    .shown_value(shown_value),
    .digit_select(digit_select),
    .digit_in(digit_in),
    .anode(anode),
    .segments(segments),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Digit parser model
  always_comb begin
    case (digit_select)
      3'd0:    digit_in = 4'(shown_value % 10);
      3'd1:    digit_in = 4'((shown_value / 10) % 10);
      3'd3:    digit_in = 4'(shown_value / 100);
      3'd4:    digit_in = 4'd0;
      default: digit_in = 4'hF;
    endcase
  end

  function automatic logic [6:0] seg_model(input logic [7:0] v, input int unsigned k);
    int unsigned p;
    int unsigned d;
    p = (k == 0) ? 1 : (k == 1) ? 10 : (k == 2) ? 100 : 1000;
    d = (int'(v) / p) % 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && int'(v) < p) return 7'b1111111;
`endif
    return segtab[d];
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic model_restart();
    t       = 0;
    shown_m = '0;
    pend_m  = '0;
    pv_m    = 1'b0;
    seg_exp = 7'b1111111;
  endtask

  // One cycle: drive inputs, check outputs at negedge, advance the model.
  task automatic step(input logic vv, input logic [7:0] v);
    int unsigned slot;
    int unsigned ph;
    logic [3:0]  an_exp;
    value_valid = vv;
    value_in    = v;
    slot   = (t / SLOT) % 4;
    ph     = t % SLOT;
    an_exp = (ph < BL) ? 4'b1111 : ~(4'b0001 << slot);
    @(negedge clk);
    check("anode", {4'b0, anode}, {4'b0, an_exp});
    check("digit_select", {5'b0, digit_select}, {5'b0, selmap[slot]});
    check("shown_value", shown_value, shown_m);
    check("frame_tick", {7'b0, frame_tick}, {7'b0, (t % FRAME == 0) && (t != 0)});
    check("segments", {1'b0, segments}, {1'b0, seg_exp});
    seg_exp = seg_model(shown_m, slot);
    if (vv) begin
      pend_m = v;
      pv_m   = 1'b1;
    end
    if ((t + 1) % FRAME == 0) begin
      if (pv_m) shown_m = pend_m;
      pv_m = 1'b0;
    end
    t++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_until(input int unsigned tt);
    while (t < tt) step(1'b0, 8'h00);
  endtask

  task automatic random_frames(input int unsigned n);
    int unsigned stop;
    stop = t + n * FRAME;
    while (t < stop) step(($urandom % 6) == 0, 8'($urandom));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_anode"}, {4'b0, anode}, 8'h0F);
    check({tag, "_segments"}, {1'b0, segments}, 8'h7F);
    check({tag, "_digit_select"}, {5'b0, digit_select}, 8'h00);
    check({tag, "_shown_value"}, shown_value, 8'h00);
    check({tag, "_frame_tick"}, {7'b0, frame_tick}, 8'h00);
  endtask

  initial begin
    reset       = 1'b1;
    value_valid = 1'b0;
    value_in    = '0;
    t           = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_restart();

    // Frame 0: load 123 during the tens slot; frame 0 still shows 0.
    idle_until(8);
    step(1'b1, 8'd123);
    idle_until(FRAME);
    // Frame 1 shows 123; load 45 then 67, only 67 reaches the display.
    idle_until(FRAME + 6);
    step(1'b1, 8'd45);
    idle_until(FRAME + 16);
    step(1'b1, 8'd67);
    // Frame 2 shows 67; load 200 on the commit edge itself.
    idle_until(3 * FRAME - 1);
    step(1'b1, 8'd200);
    // Frame 3 shows 200; load 5 for leading-zero behaviour in frame 4.
    idle_until(3 * FRAME + 8);
    step(1'b1, 8'd5);
    idle_until(5 * FRAME);
    // Load 0 for the all-zero case.
    step(1'b1, 8'd0);
    idle_until(7 * FRAME);

    random_frames(8);

    // Reset in the middle of an ON slot aborts the scan on the next edge.
    while ((t % SLOT) != BL + 1 || ((t / SLOT) % 4) != 2) step(1'b0, 8'h00);
    reset       = 1'b1;
    value_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_state("midreset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_restart();
    random_frames(3);
    idle_until(t + FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
